// File: rtl/gba_fb_scanout_if.sv
// Framebuffer read port between the VGA scanout (master) and the double buffer (slave).
//   addr : read address, y*IMG_W + x, issued by the scanout
//   data : BGR555 pixel returned READ_LATENCY cycles after addr; [4:0]=R, [9:5]=G, [14:10]=B
interface gba_fb_scanout_if;
  logic [16:0] addr;
  logic [14:0] data;

  modport master (output addr, input data);
  modport slave  (input addr, output data);
endinterface

// File: rtl/gba_fb_scanout.sv
// VGA scanout for the 240x160 GBA framebuffer.
// Generates 640x480@60 timing, reads the framebuffer with a 2x2 pixel scale into a centred
// window, and converts BGR555 to 4-bit-per-channel RGB. Sync and status flags are delayed to
// line up with the framebuffer read latency.
// Ports:
//   clock       : pixel clock (25 MHz)
//   reset       : synchronous reset, active-high
//   fb          : framebuffer read port (addr out, data in)
//   VGA_R/G/B   : 4-bit colour, black outside the image window
//   VGA_HS/VS   : active-low syncs
//   vblank      : high while the displayed line is >= V_ACTIVE
//   frame_start : one-cycle pulse aligned with screen pixel (0,0)
module gba_fb_scanout #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33,
  parameter int unsigned IMG_W        = 240,
  parameter int unsigned IMG_H        = 160,
  parameter int unsigned X_OFF        = 80,
  parameter int unsigned Y_OFF        = 80,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  gba_fb_scanout_if.master        fb,
  output logic [3:0]              VGA_R,
  output logic [3:0]              VGA_G,
  output logic [3:0]              VGA_B,
  output logic                    VGA_HS,
  output logic                    VGA_VS,
  output logic                    vblank,
  output logic                    frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned ColW    = $clog2(IMG_W + 1);

  localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HActEnd = 10'(H_ACTIVE);
  localparam logic [9:0] VActEnd = 10'(V_ACTIVE);
  localparam logic [9:0] HSyncLo = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSyncHi = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VSyncLo = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSyncHi = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] WinX0   = 10'(X_OFF);
  localparam logic [9:0] WinX1   = 10'(X_OFF + 2 * IMG_W - 1);
  localparam logic [9:0] WinY0   = 10'(Y_OFF);
  localparam logic [9:0] WinY1   = 10'(Y_OFF + 2 * IMG_H - 1);

  // Bit positions inside the delayed flag word.
  localparam int FHs  = 0;
  localparam int FVs  = 1;
  localparam int FAct = 2;
  localparam int FWin = 3;
  localparam int FVbl = 4;
  localparam int FFs  = 5;
  // Inactive flags: syncs deasserted (high), everything else low.
  localparam logic [5:0] FlagsIdle = 6'b00_0011;

  logic [9:0]      h_q, h_d;
  logic [9:0]      v_q, v_d;
  logic [16:0]     row_q, row_d;
  logic [ColW-1:0] col_q, col_d;

  logic            line_end, frame_end;
  logic            h_win, v_win, win0;
  logic [5:0]      flags0;
  logic [5:0]      pipe_q [READ_LATENCY];
  logic [5:0]      flags_out;
  logic            pix_on;
  logic            unused_data_lsbs;

  always_comb begin
    line_end  = (h_q == HLast);
    frame_end = line_end && (v_q == VLast);
    h_win     = (h_q >= WinX0) && (h_q <= WinX1);
    v_win     = (v_q >= WinY0) && (v_q <= WinY1);
    win0      = h_win && v_win;
  end

  // Screen position counters.
  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (line_end) begin
      h_d = '0;
      v_d = (v_q == VLast) ? '0 : v_q + 10'd1;
    end
  end

  // Image column/row bases. Each advances after the second of a pixel/line pair, which gives the
  // 2x2 replication without a multiplier. Parity is taken relative to the window origin.
  always_comb begin
    col_d = col_q;
    if (line_end) begin
      col_d = '0;
    end else if (win0 && (h_q[0] ^ WinX0[0])) begin
      col_d = col_q + ColW'(1);
    end
  end

  always_comb begin
    row_d = row_q;
    if (frame_end) begin
      row_d = '0;
    end else if (line_end && v_win && (v_q[0] ^ WinY0[0])) begin
      row_d = row_q + 17'(IMG_W);
    end
  end

  always_comb begin
    fb.addr = win0 ? (row_q + 17'(col_q)) : '0;
  end

  always_comb begin
    flags0       = '0;
    flags0[FHs]  = !((h_q >= HSyncLo) && (h_q <= HSyncHi));
    flags0[FVs]  = !((v_q >= VSyncLo) && (v_q <= VSyncHi));
    flags0[FAct] = (h_q < HActEnd) && (v_q < VActEnd);
    flags0[FWin] = win0;
    flags0[FVbl] = (v_q >= VActEnd);
    flags0[FFs]  = (h_q == '0) && (v_q == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_q   <= '0;
      v_q   <= '0;
      row_q <= '0;
      col_q <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        pipe_q[i] <= FlagsIdle;
      end
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      row_q     <= row_d;
      col_q     <= col_d;
      pipe_q[0] <= flags0;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // The last flag stage lines up with the data returned for the same pixel, so colour is the
  // returned pixel gated by the registered window flag; data is ignored outside the window.
  always_comb begin
    flags_out   = pipe_q[READ_LATENCY-1];
    pix_on      = flags_out[FWin] && flags_out[FAct];
    VGA_R       = pix_on ? fb.data[4:1]   : 4'h0;
    VGA_G       = pix_on ? fb.data[9:6]   : 4'h0;
    VGA_B       = pix_on ? fb.data[14:11] : 4'h0;
    VGA_HS      = flags_out[FHs];
    VGA_VS      = flags_out[FVs];
    vblank      = flags_out[FVbl];
    frame_start = flags_out[FFs];
  end

  // Colour LSBs are dropped in the 5-to-4 bit conversion.
  assign unused_data_lsbs = ^{fb.data[0], fb.data[5], fb.data[10]};

endmodule

// File: tb/tb_gba_fb_scanout.sv
// Bench for gba_fb_scanout. Horizontal timing is the full 640x480 line; the vertical geometry
// and image height are shrunk so whole frames fit in a short run.
module tb_gba_fb_scanout;

  localparam int HA = 640, HFP = 16, HSW = 96, HBP = 48;
  localparam int VA = 32, VFP = 10, VSW = 2, VBP = 3;
  localparam int IW = 240, IH = 8, XO = 80, YO = 8, LAT = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gba_fb_scanout_if fb_if ();
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vblank, frame_start;

  gba_fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .IMG_W(IW), .IMG_H(IH), .X_OFF(XO), .Y_OFF(YO), .READ_LATENCY(LAT)
  ) dut (
    .clock(clk),
    .reset(reset),
    .fb(fb_if),
    .VGA_R(vga_r),
    .VGA_G(vga_g),
    .VGA_B(vga_b),
    .VGA_HS(vga_hs),
    .VGA_VS(vga_vs),
    .vblank(vblank),
    .frame_start(frame_start)
  );

  // Framebuffer stub with LAT cycles of read latency.
  logic [14:0] mem [IW*IH];
  logic [14:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= (int'(fb_if.addr) < IW * IH) ? mem[int'(fb_if.addr)] : 15'h0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign fb_if.data = rd_pipe[LAT-1];

  int checks = 0, failures = 0;
  int n = 0;
  bit measure = 1'b0;
  int hs_low = 0, hs_first = -1, vs_low = 0, vbl_cnt = 0, fs1 = -1, fs2 = -1;

  // Directed address points (screen h, v) -> literal address.
  int          a_h [8] = '{80, 81, 82, 80, 80, 559, 79, 560};
  int          a_v [8] = '{8, 8, 8, 9, 10, 23, 8, 8};
  logic [16:0] a_e [8] = '{17'd0, 17'd0, 17'd1, 17'd0, 17'd240, 17'd1919, 17'd0, 17'd0};
  // Directed colour points (screen h, v) -> literal {R,G,B}.
  int          c_h [5] = '{80, 82, 84, 86, 10};
  int          c_v [5] = '{8, 8, 8, 8, 10};
  logic [11:0] c_e [5] = '{12'hFFF, 12'hF00, 12'h0F0, 12'h00F, 12'h000};

  function automatic int h_of(int k);
    return k % HT;
  endfunction

  function automatic int v_of(int k);
    return (k / HT) % VT;
  endfunction

  function automatic bit in_win(int h, int v);
    return (h >= XO) && (h < XO + 2 * IW) && (v >= YO) && (v < YO + 2 * IH);
  endfunction

  function automatic logic [16:0] ref_addr(int h, int v);
    if (in_win(h, v)) return 17'(((v - YO) / 2) * IW + (h - XO) / 2);
    return 17'd0;
  endfunction

  // Expected {R,G,B,HS,VS,vblank,frame_start} at observation k (k cycles after restart).
  function automatic logic [15:0] ref_out(int k);
    int h, v;
    logic [14:0] px;
    logic [11:0] rgb;
    if (k < LAT) return 16'h000C;
    h = h_of(k - LAT);
    v = v_of(k - LAT);
    rgb = 12'h000;
    if (in_win(h, v)) begin
      px = mem[int'(ref_addr(h, v))];
      rgb = {px[4:1], px[9:6], px[14:11]};
    end
    return {rgb, !(h >= HA + HFP && h < HA + HFP + HSW), !(v >= VA + VFP && v < VA + VFP + VSW),
            (v >= VA), (h == 0 && v == 0)};
  endfunction

  task automatic compare();
    logic [15:0] obs;
    logic [16:0] exp_a;
    logic [15:0] exp_o;
    obs   = {vga_r, vga_g, vga_b, vga_hs, vga_vs, vblank, frame_start};
    exp_a = ref_addr(h_of(n), v_of(n));
    exp_o = ref_out(n);
    checks++;
    assert (fb_if.addr === exp_a) else begin
      failures++;
      $error("FAIL addr n=%0d h=%0d v=%0d observed=%0d expected=%0d",
             n, h_of(n), v_of(n), fb_if.addr, exp_a);
    end
    checks++;
    assert (obs === exp_o) else begin
      failures++;
      $error("FAIL outputs n=%0d observed=%h expected=%h", n, obs, exp_o);
    end
    for (int i = 0; i < 8; i++) begin
      if (h_of(n) == a_h[i] && v_of(n) == a_v[i]) begin
        checks++;
        assert (fb_if.addr === a_e[i]) else begin
          failures++;
          $error("FAIL addr_point (%0d,%0d) observed=%0d expected=%0d",
                 a_h[i], a_v[i], fb_if.addr, a_e[i]);
        end
      end
    end
    if (n >= LAT) begin
      for (int i = 0; i < 5; i++) begin
        if (h_of(n - LAT) == c_h[i] && v_of(n - LAT) == c_v[i]) begin
          checks++;
          assert ({vga_r, vga_g, vga_b} === c_e[i]) else begin
            failures++;
            $error("FAIL colour_point (%0d,%0d) observed=%h expected=%h",
                   c_h[i], c_v[i], {vga_r, vga_g, vga_b}, c_e[i]);
          end
        end
      end
    end
    if (measure) begin
      if (n >= 1 && n <= HT && !vga_hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = n;
      end
      if (n >= 1 && n <= FRAME) begin
        if (!vga_vs) vs_low++;
        if (vblank) vbl_cnt++;
      end
      if (frame_start) begin
        if (fs1 < 0) fs1 = n;
        else if (fs2 < 0) fs2 = n;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
    compare();
  endtask

  task automatic run(int cnt);
    for (int i = 0; i < cnt; i++) begin
      if (failures > 20) break;
      step();
    end
  endtask

  task automatic check_reset_state(string tag);
    logic [32:0] obs;
    obs = {fb_if.addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vblank, frame_start};
    checks++;
    assert (obs === {17'd0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0}) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs,
             {17'd0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0});
    end
  endtask

  task automatic check_val(string tag, int obs, int expv);
    checks++;
    assert (obs == expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  initial begin
    for (int i = 0; i < IW * IH; i++) mem[i] = 15'($urandom);
    mem[0] = 15'h7FFF;
    mem[1] = 15'h001F;
    mem[2] = 15'h03E0;
    mem[3] = 15'h7C00;

    // Power-on reset held for 5 cycles.
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_reset_state("reset_hold");

    reset = 1'b0;
    n = 0;
    measure = 1'b1;
    compare();
    // One full frame plus the first frame_start of the next, stopping at (300,20).
    run(FRAME + 20 * HT + 300);
    measure = 1'b0;

    check_val("hs_first_low", hs_first, LAT + HA + HFP);
    check_val("hs_low_cycles", hs_low, HSW);
    check_val("vs_low_cycles", vs_low, VSW * HT);
    check_val("vblank_cycles", vbl_cnt, (VT - VA) * HT);
    check_val("frame_start_first", fs1, LAT);
    check_val("frame_period", fs2 - fs1, FRAME);

    // One-cycle reset in the middle of the image window.
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("mid_reset");
    reset = 1'b0;
    n = 0;
    compare();
    run(10 * HT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
